// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S receiver and transmitter.
//   i2s_state_t        : receiver word-tracking states
//   BCK_CLK            : clk cycles per nominal BCK period
//   LRCK_CLK           : clk cycles per nominal LRCK (frame) period
//   DEF_SLOT_WIDTH     : default BCK periods per channel slot
package i2s_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  localparam int unsigned BCK_CLK        = 24;
  localparam int unsigned LRCK_CLK       = 1536;
  localparam int unsigned DEF_SLOT_WIDTH = 32;

endpackage

// File: rtl/i2s_in_sync.sv
// i2s_in_sync: 2-FF synchronizer for one asynchronous input bit, with an
// optional rising-edge detector on the synchronized value.
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   i_d      in  asynchronous input
//   o_q      out synchronized level
//   o_rise   out one-clk pulse on a synchronized rising edge (0 if EDGE_DET=0)
module i2s_in_sync #(
  parameter bit EDGE_DET = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

  generate
    if (EDGE_DET) begin : g_edge
      logic r_s3;
      always_ff @(posedge clk) begin
        if (!reset_n) r_s3 <= 1'b0;
        else          r_s3 <= r_s2;
      end
      assign o_rise = r_s2 & ~r_s3;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: slave-mode I2S (Philips, MSB first, 1-bit delay) stereo receiver.
//   clk        in  system clock
//   reset_n    in  synchronous active-low reset
//   BCK        in  bit clock (async)
//   LRCK       in  word select (async), 0 = left, 1 = right
//   DATA       in  serial data (async)
//   out_left   out signed left sample (first OUT_WIDTH bits of the word)
//   out_right  out signed right sample
//   out_valid  out one-clk pulse when a new pair is presented
//   frame_err  out one-clk pulse on a malformed channel word
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned SLOT_WIDTH = DEF_SLOT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 BCK,
  input  logic                 LRCK,
  input  logic                 DATA,
  output logic [OUT_WIDTH-1:0] out_left,
  output logic [OUT_WIDTH-1:0] out_right,
  output logic                 out_valid,
  output logic                 frame_err
);

  logic w_bck_rise;
  logic w_lrck;
  logic w_data;
  logic w_bck_q_unused;
  logic w_lrck_rise_unused;
  logic w_data_rise_unused;

  i2s_in_sync #(.EDGE_DET(1'b1)) u_sync_bck (
    .clk(clk), .reset_n(reset_n), .i_d(BCK),  .o_q(w_bck_q_unused), .o_rise(w_bck_rise)
  );
  i2s_in_sync #(.EDGE_DET(1'b0)) u_sync_lrck (
    .clk(clk), .reset_n(reset_n), .i_d(LRCK), .o_q(w_lrck), .o_rise(w_lrck_rise_unused)
  );
  i2s_in_sync #(.EDGE_DET(1'b0)) u_sync_data (
    .clk(clk), .reset_n(reset_n), .i_d(DATA), .o_q(w_data), .o_rise(w_data_rise_unused)
  );

  i2s_state_t           r_state;
  i2s_state_t           w_state_nxt;
  logic                 r_bck_rise;
  logic                 r_lr_prev;
  logic [5:0]           r_bit_cnt;
  logic [OUT_WIDTH-1:0] r_word;
  logic [OUT_WIDTH-1:0] r_left_hold;
  logic [OUT_WIDTH-1:0] r_out_left;
  logic [OUT_WIDTH-1:0] r_out_right;
  logic                 r_valid;
  logic                 r_err;
  logic                 w_trans;
  logic                 w_well;
  logic                 w_valid_nxt;
  logic                 w_err_nxt;
  logic                 w_latch_left;

  // Receive actions run one clk after the synchronized edge; LRCK/DATA are
  // still well inside their stable window at that point.
  assign w_trans = r_bck_rise && (w_lrck != r_lr_prev);
  assign w_well  = (r_bit_cnt == 6'(SLOT_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= HUNT;
    else          r_state <= w_state_nxt;
  end

  // Transitions alternate, so LEFT only ever sees a rising one and RIGHT
  // only a falling one.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    w_latch_left = 1'b0;
    if (w_trans) begin
      case (r_state)
        HUNT: begin
          if (!w_lrck) w_state_nxt = LEFT;
        end
        LEFT: begin
          if (w_lrck) begin
            if (w_well) begin
              w_latch_left = 1'b1;
              w_state_nxt  = RIGHT;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = HUNT;
            end
          end
        end
        RIGHT: begin
          if (!w_lrck) begin
            if (w_well) w_valid_nxt = 1'b1;
            else        w_err_nxt   = 1'b1;
            w_state_nxt = LEFT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bck_rise  <= 1'b0;
      r_lr_prev   <= 1'b0;
      r_bit_cnt   <= '0;
      r_word      <= '0;
      r_left_hold <= '0;
      r_out_left  <= '0;
      r_out_right <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_bck_rise <= w_bck_rise;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      if (w_latch_left) r_left_hold <= r_word;
      if (w_valid_nxt) begin
        r_out_left  <= r_left_hold;
        r_out_right <= r_word;
      end
      if (r_bck_rise) begin
        if (w_trans) begin
          // This edge carries the previous word's LSB; start a fresh word.
          r_word    <= '0;
          r_bit_cnt <= '0;
          r_lr_prev <= w_lrck;
        end else begin
          // Bits past OUT_WIDTH match no index and are dropped.
          for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
            if (r_bit_cnt == 6'(OUT_WIDTH - 1 - i)) r_word[i] <= w_data;
          end
          if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
        end
      end
    end
  end

  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign out_valid = r_valid;
  assign frame_err = r_err;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed, table-driven bench for i2s_rx. Drives an I2S stream
// (BCK = clk/24, data/LRCK changed on BCK fall) and checks decoded samples,
// valid/error pulses, latency, frame period and reset behaviour.
module tb_i2s_rx;

  logic        clk;
  logic        reset_n;
  logic        BCK;
  logic        LRCK;
  logic        DATA;
  logic [23:0] out_left;
  logic [23:0] out_right;
  logic        out_valid;
  logic        frame_err;

  i2s_rx #(.OUT_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .BCK(BCK), .LRCK(LRCK), .DATA(DATA),
    .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          llen;
    int          rlen;
    int          exp_v;
    int          exp_e;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int valid_cyc = 0;
  int prev_valid_cyc = 0;
  int valid_lat = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cnt++;
      prev_valid_cyc = valid_cyc;
      valid_cyc      = cyc;
      valid_lat      = cyc - last_rise_cyc;
    end
    if (frame_err) err_cnt++;
    if (out_valid && frame_err) overlap_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One BCK period: falling edge with new LRCK/DATA, rising edge 12 clk later.
  task automatic bck_bit(input logic lr, input logic d);
    BCK  = 1'b0;
    LRCK = lr;
    DATA = d;
    repeat (12) @(negedge clk);
    BCK = 1'b1;
    last_rise_cyc = cyc;
    repeat (12) @(negedge clk);
  endtask

  // Word of len BCKs, MSB first; LRCK switches to nxt on the last (LSB) bit.
  task automatic send_word(input logic ch, input logic [31:0] val, input int len, input logic nxt);
    logic [31:0] sh;
    sh = val;
    for (int i = 0; i < len; i++) begin
      bck_bit((i == len - 1) ? nxt : ch, sh[31]);
      sh = sh << 1;
    end
  endtask

  task automatic do_reset();
    BCK     = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int v0;
    int e0;

    BCK = 1'b0; LRCK = 1'b1; DATA = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_left",  64'(out_left),  64'h0);
    check("rst_right", 64'(out_right), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_err",   64'(frame_err), 64'h0);

    //          left          right         llen rlen v  e  out_left   out_right
    tbl[0] = '{32'h123456AB, 32'hFEDCBA98, 32, 32, 1, 0, 24'h123456, 24'hFEDCBA};
    tbl[1] = '{32'h80000000, 32'h7FFFFFFF, 32, 32, 1, 0, 24'h800000, 24'h7FFFFF};
    tbl[2] = '{32'h11111111, 32'h22222222, 31, 32, 0, 1, 24'h800000, 24'h7FFFFF};
    tbl[3] = '{32'h7FC00000, 32'h80000000, 32, 32, 1, 0, 24'h7FC000, 24'h800000};
    tbl[4] = '{32'hAAAAAAAA, 32'h55555555, 32, 33, 0, 1, 24'h7FC000, 24'h800000};
    tbl[5] = '{32'hA5A5A5FF, 32'h5A5A5A00, 32, 32, 1, 0, 24'hA5A5A5, 24'h5A5A5A};
    tbl[6] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 20, 32, 0, 1, 24'hA5A5A5, 24'h5A5A5A};
    tbl[7] = '{32'h00000100, 32'hFFFFFF00, 32, 32, 1, 0, 24'h000001, 24'hFFFFFF};

    // Right-channel preamble ends with the LRCK fall that opens the first frame.
    send_word(1'b1, 32'h0, 32, 1'b0);

    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_word(1'b0, tbl[i].l, tbl[i].llen, 1'b1);
      send_word(1'b1, tbl[i].r, tbl[i].rlen, 1'b0);
      check($sformatf("vec%0d_valid", i), 64'(valid_cnt - v0), 64'(tbl[i].exp_v));
      check($sformatf("vec%0d_err",   i), 64'(err_cnt - e0),   64'(tbl[i].exp_e));
      check($sformatf("vec%0d_left",  i), 64'(out_left),       64'(tbl[i].exp_l));
      check($sformatf("vec%0d_right", i), 64'(out_right),      64'(tbl[i].exp_r));
      if (i == 0) check("latency", 64'(valid_lat), 64'd4);
      if (i == 1) check("period", 64'(valid_cyc - prev_valid_cyc), 64'd1536);
    end

    // Stream picked up mid right channel: only the next full pair is output.
    do_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    send_word(1'b1, 32'hDEADBEEF, 20, 1'b0);
    check("mid_partial_valid", 64'(valid_cnt - v0), 64'h0);
    check("mid_partial_err",   64'(err_cnt - e0),   64'h0);
    send_word(1'b0, 32'h11223344, 32, 1'b1);
    send_word(1'b1, 32'h55667788, 32, 1'b0);
    check("mid_valid", 64'(valid_cnt - v0), 64'h1);
    check("mid_err",   64'(err_cnt - e0),   64'h0);
    check("mid_left",  64'(out_left),       64'h112233);
    check("mid_right", 64'(out_right),      64'h556677);

    // Reset during bit 10 of the right word.
    send_word(1'b0, 32'h0BADF00D, 32, 1'b1);
    send_word(1'b1, 32'hCAFEBABE, 10, 1'b1);
    v0 = valid_cnt;
    e0 = err_cnt;
    do_reset();
    check("rmid_left",  64'(out_left),  64'h0);
    check("rmid_right", 64'(out_right), 64'h0);
    check("rmid_valid", 64'(out_valid), 64'h0);
    check("rmid_err",   64'(frame_err), 64'h0);
    send_word(1'b1, 32'hCAFEBABE << 10, 22, 1'b0);
    send_word(1'b0, 32'h33333333, 32, 1'b1);
    send_word(1'b1, 32'h44444444, 32, 1'b0);
    check("rmid_pairs",   64'(valid_cnt - v0), 64'h1);
    check("rmid_errs",    64'(err_cnt - e0),   64'h0);
    check("rmid_left_v",  64'(out_left),       64'h333333);
    check("rmid_right_v", 64'(out_right),      64'h444444);

    check("valid_err_overlap", 64'(overlap_cnt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Slave-mode I2S receiver: samples external BCK/LRCK/DATA asynchronously in the `clk` domain, deserializes standard-format (Philips, MSB first, 1-bit delay) stereo frames, and presents signed left/right samples with a one-cycle valid pulse. It is the input-side counterpart of the on-board I2S transmitter, for codec/ADC capture into the FM processing chain.

## Interface
- OUT_WIDTH, 24: output sample width; first OUT_WIDTH bits of each channel word are kept.
- SLOT_WIDTH, 32: expected BCK periods per channel; range 16..63, and OUT_WIDTH ≤ SLOT_WIDTH.
- clk  in  1  system clock, 73.728 MHz.
- reset_n  in  1  synchronous, active-low reset.
- BCK  in  1  bit clock, asynchronous to clk.
- LRCK  in  1  word select, asynchronous to clk; 0 = left, 1 = right.
- DATA  in  1  serial data, asynchronous to clk.
- out_left  out  OUT_WIDTH  signed left sample; reset 0.
- out_right  out  OUT_WIDTH  signed right sample; reset 0.
- out_valid  out  1  one-clk pulse when a new pair is present; reset 0.
- frame_err  out  1  one-clk pulse on a malformed channel word; reset 0.

## Operation
- BCK, LRCK and DATA each pass through a 2-FF synchronizer, plus one further register on BCK for edge detection.
- All receive actions occur on a synchronized BCK rising edge (`bck_rise`). No action occurs on any other clk cycle.
- At each `bck_rise`, the synchronized LRCK is compared with `lr_prev`, the LRCK value captured at the previous `bck_rise`. A difference is a transition edge. A falling transition is 1→0 and a rising transition is 0→1.
- Non-transition `bck_rise`:
  - If `bit_cnt` < OUT_WIDTH, DATA is written to `word[OUT_WIDTH-1-bit_cnt]`. Bits beyond OUT_WIDTH are discarded (truncation, no rounding).
  - `bit_cnt` then increments, saturating at 63.
- Transition `bck_rise`:
  - The DATA bit on this edge is the previous word's LSB and is ignored.
  - The word just finished is well-formed only if `bit_cnt` == SLOT_WIDTH-1.
  - The finished word is then processed per state (below). Afterwards `word` is cleared to 0, `bit_cnt` is set to 0, and `lr_prev` is updated.
- States:
  - HUNT (reset state): falling transition → LEFT. All other edges are ignored and no output is produced.
  - LEFT, rising transition:
    - Well-formed word: latch `word` into the `left_hold` register and go to RIGHT.
    - Malformed word: pulse frame_err and go to HUNT.
  - RIGHT, falling transition:
    - Well-formed word: on the next clk, `out_left` ← `left_hold`, `out_right` ← `word`, and out_valid pulses. Go to LEFT.
    - Malformed word: pulse frame_err, produce no output, and go to LEFT.
- The outputs `out_left` and `out_right` hold their values until the next valid pair is presented.
- Words shorter than OUT_WIDTH are only possible in frames that are flagged as errors, so zero-fill of the remaining LSBs is never presented at the outputs.

## Timing
- Input requirement: BCK high and low phases must each be ≥ 3 clk. Nominal is 12 clk (BCK = clk/24, fs = clk/1536).
- DATA and LRCK must be stable ≥ 2 clk around each BCK rising edge. The transmitter side changes them on BCK falling edges.
- Latency: out_valid is asserted exactly 4 clk after the pin-level BCK rising edge that carries the LRCK falling transition. The 4 clk are: 2 sync + 1 edge register + 1 output register.
- out_left and out_right update in the same cycle that out_valid is high.
- frame_err is asserted 1 clk after the offending `bck_rise`. frame_err and out_valid are never high in the same cycle.
- Steady state: one out_valid every 2·SLOT_WIDTH BCK periods, i.e. 1536 clk at nominal rates.
- First pair after reset or after HUNT: at least one full left word plus one full right word must be received first. No partial pair is ever emitted.
- Reset mid-frame: all state is cleared within the reset cycle and the block returns to HUNT. The frame in flight is discarded without a frame_err pulse.
- BCK stopping: state is held indefinitely; there is no timeout.

## Structure
- Package `i2s_pkg` contains:
  - the state enum (HUNT, LEFT, RIGHT);
  - the shared constants BCK_CLK = 24 and LRCK_CLK = 1536;
  - the default SLOT_WIDTH = 32.
  The transmitter also uses this package.
- Sub-module `i2s_in_sync`: per-bit 2-FF synchronizer plus optional edge-detect output. One instance each for BCK, LRCK and DATA.
- Top level `i2s_rx` contains the bit counter, word shift logic, state machine and output registers.

## Test plan
- Nominal frame (BCK = clk/24, SLOT 32) with L = 0x123456AB, R = 0xFEDCBA98 → out_left = 0x123456, out_right = 0xFEDCBA (negative). out_valid fires 4 clk after the pin-level LRCK-falling BCK edge, then every 1536 clk for repeated frames.
- Start stimulus mid-right-channel after reset → the first out_valid comes only after the next complete L+R pair, with no spurious pulse and frame_err = 0.
- Left word of 31 BCKs → frame_err pulse at the LRCK rise, block returns to HUNT, no out_valid for that frame. The next clean pair is received correctly.
- Full-scale values L = 0x80000000, R = 0x7FFFFFFF → out_left = 0x800000, out_right = 0x7FFFFF.
- Assert reset_n = 0 during bit 10 of the right word → outputs, out_valid and frame_err return to 0. The following two frames yield exactly one valid pair, from the first complete frame after HUNT.
- Loopback against the I2S transmitter (volume = 0, 10-bit input 0x1FF / 0x200) → received 24-bit samples equal the transmitted values shifted left by 14.
